// File: rtl/hazard_if.sv
// Bundle of pipeline hazard signals shared by the hazard controller and the pipeline datapath.
// The master side drives hazard sources; the slave side (hazard_ctrl) drives stall/flush controls.
interface hazard_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_MemRead;
  logic        ex_redirect;
  logic        mem_busy;
  logic        if_busy;

  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_stall;
  logic        id_ex_flush;
  logic        ex_mem_stall;
  logic        ex_mem_flush;
  logic        stall_timeout;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
  logic [31:0] perf_load_use;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead, ex_redirect,
           mem_busy, if_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           ex_mem_flush, stall_timeout, perf_stall_cycles, perf_flushes, perf_load_use
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead, ex_redirect,
           mem_busy, if_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           ex_mem_flush, stall_timeout, perf_stall_cycles, perf_flushes, perf_load_use
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze, redirect flush drain, load-use bubble, fetch-wait bubble,
// plus a memory-stall watchdog. Define HAZARD_PERF_CNT_EN to build the performance counters.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  localparam logic [2:0]  FlushLoad   = 3'(FLUSH_CYCLES);
  localparam logic [15:0] TimeoutLast = 16'(STALL_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StRedirect} state_e;

  state_e      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] busy_cnt_q;
  logic        timeout_q;

  logic load_use;
  logic lu_bubble;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush;

  assign load_use = hz.ex_MemRead && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    lu_bubble    = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst) begin
      // Outputs held low; registered state is cleared by the state register.
    end else if (hz.mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (hz.ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        flush_cnt_d = FlushLoad;
        state_d     = StRedirect;
      end
    end else if (state_q == StRedirect) begin
      // ID already holds a bubble here, so load-use need not be checked.
      if_id_flush = 1'b1;
      if (flush_cnt_q <= 3'd1) begin
        flush_cnt_d = 3'd0;
        state_d     = StRun;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      lu_bubble   = 1'b1;
    end else if (hz.if_busy) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Watchdog: count consecutive mem_busy cycles; the error is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else if (hz.mem_busy) begin
      if (busy_cnt_q != 16'hFFFF) begin
        busy_cnt_q <= busy_cnt_q + 16'd1;
      end
      if (busy_cnt_q == TimeoutLast) begin
        timeout_q <= 1'b1;
      end
    end else begin
      busy_cnt_q <= 16'd0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_lu_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_lu_q    <= 32'd0;
    end else begin
      if (pc_stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (hz.ex_redirect && !hz.mem_busy) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
      if (lu_bubble) begin
        perf_lu_q <= perf_lu_q + 32'd1;
      end
    end
  end

  assign hz.perf_stall_cycles = perf_stall_q;
  assign hz.perf_flushes      = perf_flush_q;
  assign hz.perf_load_use     = perf_lu_q;
`else
  logic unused_perf;
  assign unused_perf          = lu_bubble;
  assign hz.perf_stall_cycles = 32'd0;
  assign hz.perf_flushes      = 32'd0;
  assign hz.perf_load_use     = 32'd0;
`endif

  assign hz.pc_stall      = pc_stall;
  assign hz.if_id_stall   = if_id_stall;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_stall   = id_ex_stall;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_stall  = ex_mem_stall;
  assign hz.ex_mem_flush  = ex_mem_flush;
  assign hz.stall_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_CYCLES=2 and STALL_TIMEOUT=4.
// Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush}.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned PerfOn = 1;
`else
  localparam int unsigned PerfOn = 0;
`endif

  localparam logic [6:0] PatIdle   = 7'b0000000;
  localparam logic [6:0] PatFreeze = 7'b1101010;
  localparam logic [6:0] PatRedir  = 7'b0010100;
  localparam logic [6:0] PatDrain  = 7'b0010000;
  localparam logic [6:0] PatLdUse  = 7'b1100100;
  localparam logic [6:0] PatFetch  = 7'b1010000;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  hazard_if hif ();

  hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .STALL_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {hif.pc_stall, hif.if_id_stall, hif.if_id_flush, hif.id_ex_stall, hif.id_ex_flush,
            hif.ex_mem_stall, hif.ex_mem_flush};
  endfunction

  // Advance one rising edge; inputs change 1 time unit after it, checks follow 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hif.id_rs1      = 5'd0;
    hif.id_rs2      = 5'd0;
    hif.id_uses_rs1 = 1'b0;
    hif.id_uses_rs2 = 1'b0;
    hif.ex_rd       = 5'd0;
    hif.ex_MemRead  = 1'b0;
    hif.ex_redirect = 1'b0;
    hif.mem_busy    = 1'b0;
    hif.if_busy     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    hif.mem_busy    = 1'b1;
    hif.ex_redirect = 1'b1;
    #2;
    vectors++;
    if (outs() !== PatIdle) begin
      miscompares++;
      $display("FAIL reset_forces_zero: got %b want %b", outs(), PatIdle);
    end
    step();
    idle_inputs();
    step();
    rst = 1'b0;
    #2;
    vectors++;
    if (outs() !== PatIdle || hif.stall_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b/%b want %b/0", outs(), hif.stall_timeout, PatIdle);
    end
    vectors++;
    if (hif.perf_stall_cycles !== 32'd0 || hif.perf_load_use !== 32'd0 ||
        hif.perf_flushes !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", hif.perf_stall_cycles,
               hif.perf_flushes, hif.perf_load_use);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    hif.ex_MemRead  = 1'b1;
    hif.ex_rd       = 5'd5;
    hif.id_rs1      = 5'd5;
    hif.id_uses_rs1 = 1'b1;
    #2;
    vectors++;
    if (outs() !== PatLdUse) begin
      miscompares++;
      $display("FAIL load_use_rs1: got %b want %b", outs(), PatLdUse);
    end
    step();
    hif.ex_MemRead = 1'b0;
    hif.ex_rd      = 5'd9;
    #2;
    vectors++;
    if (outs() !== PatIdle) begin
      miscompares++;
      $display("FAIL load_use_gone: got %b want %b", outs(), PatIdle);
    end
    vectors++;
    if (hif.perf_load_use !== 32'(PerfOn) || hif.perf_stall_cycles !== 32'(PerfOn)) begin
      miscompares++;
      $display("FAIL load_use_perf: got %0d/%0d want %0d/%0d", hif.perf_load_use,
               hif.perf_stall_cycles, PerfOn, PerfOn);
    end
    idle_inputs();
    hif.ex_MemRead  = 1'b1;
    hif.ex_rd       = 5'd7;
    hif.id_rs2      = 5'd7;
    hif.id_uses_rs2 = 1'b1;
    hif.id_rs1      = 5'd3;
    #2;
    vectors++;
    if (outs() !== PatLdUse) begin
      miscompares++;
      $display("FAIL load_use_rs2: got %b want %b", outs(), PatLdUse);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_no_hazard();
    idle_inputs();
    hif.ex_MemRead  = 1'b1;
    hif.ex_rd       = 5'd0;
    hif.id_rs2      = 5'd0;
    hif.id_uses_rs2 = 1'b1;
    #2;
    vectors++;
    if (outs() !== PatIdle) begin
      miscompares++;
      $display("FAIL no_hazard_x0: got %b want %b", outs(), PatIdle);
    end
    step();
    idle_inputs();
    hif.ex_MemRead = 1'b1;
    hif.ex_rd      = 5'd5;
    hif.id_rs1     = 5'd5;
    #2;
    vectors++;
    if (outs() !== PatIdle) begin
      miscompares++;
      $display("FAIL no_hazard_unused_rs1: got %b want %b", outs(), PatIdle);
    end
    step();
    hif.ex_MemRead  = 1'b0;
    hif.id_uses_rs1 = 1'b1;
    #2;
    vectors++;
    if (outs() !== PatIdle) begin
      miscompares++;
      $display("FAIL no_hazard_not_load: got %b want %b", outs(), PatIdle);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_redirect_drain();
    logic [6:0] exp_seq [4];
    exp_seq = '{PatRedir, PatDrain, PatDrain, PatIdle};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i == 0) hif.ex_redirect = 1'b1;
      if (i == 2) begin
        // Load-use during the drain must not take effect.
        hif.ex_MemRead  = 1'b1;
        hif.ex_rd       = 5'd4;
        hif.id_rs1      = 5'd4;
        hif.id_uses_rs1 = 1'b1;
      end
      #2;
      vectors++;
      if (outs() !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL redirect_drain_c%0d: got %b want %b", i, outs(), exp_seq[i]);
      end
      step();
    end
    idle_inputs();
    vectors++;
    if (hif.perf_flushes !== 32'(PerfOn)) begin
      miscompares++;
      $display("FAIL redirect_perf: got %0d want %0d", hif.perf_flushes, PerfOn);
    end
  endtask

  task automatic test_freeze_redirect();
    logic [6:0] exp_seq [10];
    exp_seq = '{PatFreeze, PatFreeze, PatFreeze, PatRedir, PatDrain, PatRedir, PatDrain,
                PatDrain, PatIdle, PatIdle};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      hif.mem_busy    = (i < 3);
      hif.ex_redirect = (i < 4) || (i == 5);
      #2;
      vectors++;
      if (outs() !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL freeze_redirect_c%0d: got %b want %b", i, outs(), exp_seq[i]);
      end
      if (i == 3) begin
        vectors++;
        if (hif.stall_timeout !== 1'b0) begin
          miscompares++;
          $display("FAIL freeze_no_timeout: got %b want 0", hif.stall_timeout);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    hif.mem_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      #2;
      vectors++;
      if (hif.stall_timeout !== (i == 4)) begin
        miscompares++;
        $display("FAIL watchdog_edge%0d: got %b want %b", i, hif.stall_timeout, (i == 4));
      end
    end
    hif.mem_busy = 1'b0;
    step();
    step();
    vectors++;
    if (hif.stall_timeout !== 1'b1 || outs() !== PatIdle) begin
      miscompares++;
      $display("FAIL watchdog_sticky: got %b/%b want 1/%b", hif.stall_timeout, outs(), PatIdle);
    end
    do_reset();
    #2;
    vectors++;
    if (hif.stall_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL watchdog_reset: got %b want 0", hif.stall_timeout);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    hif.ex_redirect = 1'b1;
    step();
    hif.ex_redirect = 1'b0;
    #2;
    vectors++;
    if (outs() !== PatDrain) begin
      miscompares++;
      $display("FAIL mid_drain_pre: got %b want %b", outs(), PatDrain);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (outs() !== PatIdle) begin
      miscompares++;
      $display("FAIL mid_drain_rst: got %b want %b", outs(), PatIdle);
    end
    step();
    rst = 1'b0;
    #2;
    vectors++;
    if (outs() !== PatIdle) begin
      miscompares++;
      $display("FAIL mid_drain_after: got %b want %b", outs(), PatIdle);
    end
    hif.if_busy = 1'b1;
    #1;
    vectors++;
    if (outs() !== PatFetch) begin
      miscompares++;
      $display("FAIL fetch_wait: got %b want %b", outs(), PatFetch);
    end
    hif.ex_MemRead  = 1'b1;
    hif.ex_rd       = 5'd12;
    hif.id_rs2      = 5'd12;
    hif.id_uses_rs2 = 1'b1;
    #1;
    vectors++;
    if (outs() !== PatLdUse) begin
      miscompares++;
      $display("FAIL fetch_vs_load_use: got %b want %b", outs(), PatLdUse);
    end
    step();
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect_drain();
    test_freeze_redirect();
    test_watchdog();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
